// File: rtl/noise_gate.sv
// Streaming noise gate: open/close hysteresis, hold timer and linear gain ramps on attack and release.
// Latency: sample_out/valid_out are registered exactly one cycle after valid_in; one sample per cycle.
// No backpressure: a valid_in strobe is always accepted. Optional stats via NOISE_GATE_STATS_EN.
module noise_gate #(
    parameter int WIDTH        = 24,
    parameter int OPEN_THRESH  = 262144,
    parameter int CLOSE_THRESH = 131072,
    parameter int HOLD_SAMPLES = 4800,
    parameter int ATTACK_STEP  = 1,
    parameter int RELEASE_STEP = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic signed [WIDTH-1:0] sample_out,
    output logic                    valid_out,
    output logic                    gate_open_out
`ifdef NOISE_GATE_STATS_EN
    ,
    output logic [15:0]             open_count_out,
    output logic [WIDTH-1:0]        peak_out
`endif
);

    // Hold counter only needs to reach HOLD_SAMPLES.
    localparam int CW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES + 1) : 1;

    localparam logic [WIDTH-1:0] MAG_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] OPEN_T    = WIDTH'(OPEN_THRESH);
    localparam logic [WIDTH-1:0] CLOSE_T   = WIDTH'(CLOSE_THRESH);
    localparam logic [CW-1:0]    HOLD_LOAD = CW'(HOLD_SAMPLES);
    localparam logic [CW-1:0]    HOLD_LAST = CW'(1);
    localparam logic [8:0]       UNITY     = 9'd256;
    localparam logic [8:0]       A_STEP    = 9'(ATTACK_STEP);
    localparam logic [8:0]       R_STEP    = 9'(RELEASE_STEP);
    // Gain on the first release sample after the hold expires.
    localparam logic [8:0]       REL_FIRST = 9'(256 - RELEASE_STEP);

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                   state;
    logic [8:0]               gain;
    logic [CW-1:0]            hold_cnt;

    logic [WIDTH-1:0]         mag;
    logic                     is_loud;
    logic                     is_quiet;
    logic [9:0]               gain_sum;
    logic [8:0]               gain_up;
    logic [8:0]               gain_dn;
    logic signed [WIDTH+7:0]  prod;

    // Magnitude, threshold decisions, saturating gain steps and the gain product.
    always_comb begin
        mag      = '0;
        is_loud  = 1'b0;
        is_quiet = 1'b0;
        gain_sum = '0;
        gain_up  = '0;
        gain_dn  = '0;
        prod     = '0;

        // The most negative input has no positive twin, so clamp it.
        if (sample_in[WIDTH-1]) begin
            if ($unsigned(sample_in) == MOST_NEG) begin
                mag = MAG_MAX;
            end else begin
                mag = $unsigned(-sample_in);
            end
        end else begin
            mag = $unsigned(sample_in);
        end

        is_loud  = (mag >= OPEN_T);
        is_quiet = (mag < CLOSE_T);

        gain_sum = {1'b0, gain} + {1'b0, A_STEP};
        gain_up  = (gain_sum >= {1'b0, UNITY}) ? UNITY : gain_sum[8:0];
        gain_dn  = (gain <= R_STEP) ? 9'd0 : (gain - R_STEP);

        // gain <= 256 keeps the product inside WIDTH+8 signed bits.
        prod = (WIDTH+8)'(sample_in) * $signed((WIDTH+8)'(gain));
    end

    // Gate FSM, gain ramp, hold timer and registered outputs; advances only on valid samples.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= CLOSED;
            gain          <= '0;
            hold_cnt      <= '0;
            sample_out    <= '0;
            valid_out     <= 1'b0;
            gate_open_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                // Output uses the gain held before this sample's update.
                sample_out <= WIDTH'(prod >>> 8);
                case (state)
                    CLOSED: begin
                        if (is_loud) begin
                            gain          <= gain_up;
                            state         <= ATTACK;
                            gate_open_out <= 1'b1;
                        end
                    end
                    ATTACK: begin
                        // Quiet input does not abort an attack in progress.
                        gain <= gain_up;
                        if (gain_up == UNITY) begin
                            state <= OPEN;
                        end
                    end
                    OPEN: begin
                        if (is_quiet) begin
                            hold_cnt <= HOLD_LOAD;
                            state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!is_quiet) begin
                            state <= OPEN;
                        end else if (hold_cnt == HOLD_LAST) begin
                            gain <= REL_FIRST;
                            if (REL_FIRST == 9'd0) begin
                                state         <= CLOSED;
                                gate_open_out <= 1'b0;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    RELEASE: begin
                        // A loud sample re-attacks from the current gain.
                        if (is_loud) begin
                            gain <= gain_up;
                            if (gain_up == UNITY) begin
                                state <= OPEN;
                            end else begin
                                state <= ATTACK;
                            end
                        end else begin
                            gain <= gain_dn;
                            if (gain_dn == 9'd0) begin
                                state         <= CLOSED;
                                gate_open_out <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state         <= CLOSED;
                        gain          <= '0;
                        gate_open_out <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef NOISE_GATE_STATS_EN
    // Count gate openings and track the peak level since the most recent opening.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            open_count_out <= '0;
            peak_out       <= '0;
        end else if (valid_in) begin
            if (state == CLOSED && is_loud) begin
                open_count_out <= open_count_out + 16'd1;
                peak_out       <= mag;
            end else if (mag > peak_out) begin
                peak_out <= mag;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate: a vector table of back-to-back/spaced samples plus an async reset sequence.
// Each vector is one valid sample; outputs are sampled 1 time unit after the capturing edge.
// Expected outputs are hand-computed for HOLD=4, ATTACK_STEP=64, RELEASE_STEP=64.
module tb_noise_gate;

    localparam int W = 24;

    logic                 clk_in;
    logic                 rst_in;
    logic                 valid_in;
    logic signed [W-1:0]  sample_in;
    logic signed [W-1:0]  sample_out;
    logic                 valid_out;
    logic                 gate_open_out;
`ifdef NOISE_GATE_STATS_EN
    logic [15:0]          open_count_out;
    logic [W-1:0]         peak_out;
`endif

    noise_gate #(
        .WIDTH        (W),
        .OPEN_THRESH  (262144),
        .CLOSE_THRESH (131072),
        .HOLD_SAMPLES (4),
        .ATTACK_STEP  (64),
        .RELEASE_STEP (64)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .valid_out     (valid_out),
        .gate_open_out (gate_open_out)
`ifdef NOISE_GATE_STATS_EN
        ,
        .open_count_out(open_count_out),
        .peak_out      (peak_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int      gap;
        int      smp;
        int      exp_out;
        bit      exp_gate;
        string   name;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int gap, input int smp, input int exp_out, input bit exp_gate, input string name);
        vec_t v;
        v.gap = gap;
        v.smp = smp;
        v.exp_out = exp_out;
        v.exp_gate = exp_gate;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        int prev_out;
        bit prev_gate;

        // 1: quiet input below threshold, gate stays closed
        for (int i = 0; i < 10; i++) add((i == 1) ? 2000 : 0, 1000, 0, 1'b0, "t1_quiet");
        // 2: attack ramp from CLOSED
        add(0,    300000,      0, 1'b1, "t2_attack");
        add(0,    300000,  75000, 1'b1, "t2_attack");
        add(2000, 300000, 150000, 1'b1, "t2_attack_gap");
        add(0,    300000, 225000, 1'b1, "t2_attack");
        add(0,    300000, 300000, 1'b1, "t2_open");
        add(0,    300000, 300000, 1'b1, "t2_open");
        // 3: hold then release to CLOSED
        for (int i = 0; i < 5; i++) add(0, 100000, 100000, 1'b1, "t3_hold");
        add(0, 100000, 75000, 1'b1, "t3_release");
        add(0, 100000, 50000, 1'b1, "t3_release");
        add(0, 100000, 25000, 1'b0, "t3_release");
        add(0, 100000,     0, 1'b0, "t3_closed");
        add(0, 100000,     0, 1'b0, "t3_closed");
        // 4: reopen, partial hold interrupted by a mid-level sample, full hold restarts
        add(0, 300000,      0, 1'b1, "t4_attack");
        add(0, 300000,  75000, 1'b1, "t4_attack");
        add(0, 300000, 150000, 1'b1, "t4_attack");
        add(0, 300000, 225000, 1'b1, "t4_attack");
        add(0, 300000, 300000, 1'b1, "t4_open");
        for (int i = 0; i < 3; i++) add(0, 100000, 100000, 1'b1, "t4_hold_a");
        add(0, 140000, 140000, 1'b1, "t4_reopen");
        for (int i = 0; i < 5; i++) add(0, 100000, 100000, 1'b1, "t4_hold_b");
        add(0, 100000, 75000, 1'b1, "t4_release");
        add(0, 100000, 50000, 1'b1, "t4_release");
        add(0, 100000, 25000, 1'b0, "t4_release");
        // 5: negative input ramp, then close, then most-negative sample opens
        add(0, -300000,       0, 1'b1, "t5_neg");
        add(0, -300000,  -75000, 1'b1, "t5_neg");
        add(0, -300000, -150000, 1'b1, "t5_neg");
        add(0, -300000, -225000, 1'b1, "t5_neg");
        add(0, -300000, -300000, 1'b1, "t5_neg");
        for (int i = 0; i < 8; i++) add(0, 0, 0, (i < 7) ? 1'b1 : 1'b0, "t5_close");
        add(3, -8388608, 0, 1'b1, "t5_most_neg");

        rst_in    = 1'b1;
        valid_in  = 1'b0;
        sample_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_sample_out", sample_out, 0);
        check("reset_valid_out", valid_out, 0);
        check("reset_gate_open", gate_open_out, 0);
        rst_in = 1'b0;

        prev_out  = 0;
        prev_gate = 1'b0;
        foreach (vecs[i]) begin
            if (vecs[i].gap > 0) begin
                valid_in = 1'b0;
                repeat (vecs[i].gap) @(posedge clk_in);
                #1;
                check({vecs[i].name, "_idle_valid"}, valid_out, 0);
                check({vecs[i].name, "_idle_hold_out"}, sample_out, prev_out);
                check({vecs[i].name, "_idle_gate"}, gate_open_out, prev_gate);
            end
            valid_in  = 1'b1;
            sample_in = vecs[i].smp;
            @(posedge clk_in);
            #1;
            check({vecs[i].name, "_valid_out"}, valid_out, 1);
            check({vecs[i].name, "_sample_out"}, sample_out, vecs[i].exp_out);
            check({vecs[i].name, "_gate_open"}, gate_open_out, vecs[i].exp_gate);
            prev_out  = vecs[i].exp_out;
            prev_gate = vecs[i].exp_gate;
        end

        // 6: gate is mid-ATTACK at gain 64; one more loud sample takes it to 128
        valid_in  = 1'b1;
        sample_in = 300000;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        check("t6_pre_rst_out", sample_out, 75000);
        check("t6_pre_rst_valid", valid_out, 1);
        #2;
        rst_in = 1'b1;
        #1;
        check("t6_async_rst_out", sample_out, 0);
        check("t6_async_rst_valid", valid_out, 0);
        check("t6_async_rst_gate", gate_open_out, 0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        valid_in  = 1'b1;
        sample_in = 300000;
        @(posedge clk_in);
        #1;
        check("t6_after_rst_out", sample_out, 0);
        check("t6_after_rst_gate", gate_open_out, 1);
        @(posedge clk_in);
        #1;
        check("t6_after_rst_out2", sample_out, 75000);
        valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("t6_strobe_drop", valid_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
